// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 5-digit seven-segment scan driver.
package seg_pkg;

    localparam int NUM_DIGITS = 5;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    // Active-low one-hot digit enable: only bit d is driven low.
    function automatic logic [NUM_DIGITS-1:0] digit_enable_n(input logic [2:0] d);
        return ~(NUM_DIGITS'(1) << d);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Pattern-set handshake between a producer and the scan driver, plus the blink request.
interface seg_scan_driver_if;
    import seg_pkg::*;

    logic in_valid;
    logic in_ready;
    logic blink_en;
    seg_t seg_in0;
    seg_t seg_in1;
    seg_t seg_in2;
    seg_t seg_in3;
    seg_t seg_in4;

    modport master (
        output in_valid,
        output blink_en,
        output seg_in0,
        output seg_in1,
        output seg_in2,
        output seg_in3,
        output seg_in4,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  blink_en,
        input  seg_in0,
        input  seg_in1,
        input  seg_in2,
        input  seg_in3,
        input  seg_in4,
        output in_ready
    );

endinterface

// File: rtl/seg_scan_driver_timer.sv
// Slot/frame/blink sequencer. Exposes next-cycle values so the caller can register
// its outputs in step with this block's state.
module seg_frame_timer
    import seg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] digit_next,
    output logic       drive_next,
    output logic       blink_next,
    output logic       frame_start
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(BLINK_FRAMES + 1);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    digit_reg;
    logic [FW-1:0] frame_reg;
    logic          blink_reg;

    logic last_blank;
    logic last_drive;
    logic frame_end;

    assign last_blank = (state_reg == ST_BLANK) && (cnt_reg == BLANK_LAST);
    assign last_drive = (state_reg == ST_DRIVE) && (cnt_reg == DRIVE_LAST);
    assign frame_end  = last_drive && (digit_reg == DIGIT_LAST);

    assign state_next = last_blank ? ST_DRIVE :
                        last_drive ? ST_BLANK : state_reg;
    assign digit_next = !last_drive ? digit_reg :
                        (digit_reg == DIGIT_LAST) ? 3'd0 : digit_reg + 3'd1;
    // The phase flips on the clock that enters the first boundary of a new blink half-period.
    assign blink_next = (frame_end && (frame_reg == FRAME_LAST)) ? ~blink_reg : blink_reg;
    assign drive_next = (state_next == ST_DRIVE);

    assign frame_start = (state_reg == ST_BLANK) && (digit_reg == 3'd0) && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
            digit_reg <= 3'd0;
            frame_reg <= '0;
            blink_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            digit_reg <= digit_next;
            blink_reg <= blink_next;
            cnt_reg   <= (last_blank || last_drive) ? '0 : cnt_reg + CW'(1);
            if (frame_end) begin
                frame_reg <= (frame_reg == FRAME_LAST) ? '0 : frame_reg + FW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Five-digit multiplexed seven-segment driver with a double-buffered pattern set that
// only swaps at frame boundaries, blanking guard slots and optional whole-display blink.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_driver_if.slave      bus,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic [6:0]            seg_out
);

    logic [2:0] digit_next;
    logic       drive_next;
    logic       blink_next;
    logic       frame_start;

    seg_frame_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_next  (digit_next),
        .drive_next  (drive_next),
        .blink_next  (blink_next),
        .frame_start (frame_start)
    );

    logic pending_reg;
    logic accept;
    logic commit;

    assign bus.in_ready = !pending_reg;
    assign accept       = bus.in_valid && !pending_reg;
    assign commit       = frame_start && pending_reg;

    seg_t seg_in_arr  [NUM_DIGITS];
    seg_t active_next [NUM_DIGITS];

    assign seg_in_arr[0] = bus.seg_in0;
    assign seg_in_arr[1] = bus.seg_in1;
    assign seg_in_arr[2] = bus.seg_in2;
    assign seg_in_arr[3] = bus.seg_in3;
    assign seg_in_arr[4] = bus.seg_in4;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            seg_t shadow_reg;
            seg_t active_reg;

            assign active_next[gi] = commit ? shadow_reg : active_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_reg <= SEG_BLANK;
                    active_reg <= SEG_BLANK;
                end else begin
                    if (accept) begin
                        shadow_reg <= seg_in_arr[gi];
                    end
                    active_reg <= active_next[gi];
                end
            end
        end
    endgenerate

    logic [NUM_DIGITS-1:0] an_out_reg;
    seg_t                  seg_out_reg;

    // Outputs are built from next-cycle timer values so they line up with the timer state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            an_out_reg  <= '1;
            seg_out_reg <= SEG_BLANK;
        end else begin
            if (commit) begin
                pending_reg <= 1'b0;
            end else if (accept) begin
                pending_reg <= 1'b1;
            end
            an_out_reg  <= (drive_next && !(bus.blink_en && blink_next)) ?
                           digit_enable_n(digit_next) : '1;
            seg_out_reg <= drive_next ? active_next[digit_next] : SEG_BLANK;
        end
    end

    assign an_out  = an_out_reg;
    assign seg_out = seg_out_reg;

endmodule
